// File: rtl/i16_coef_loader_pkg.sv
// Shared constants and types for the biquad coefficient loader:
// coefficient addresses, pass-through reset values and FSM encoding.
package i16_coef_loader_pkg;

  localparam int COEF_NUM = 5;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  // Pass-through filter: b_0 = 1.0 in Q2.14, everything else zero.
  localparam logic [15:0] RST_B0 = 16'h4000;
  localparam logic [15:0] RST_B1 = 16'h0000;
  localparam logic [15:0] RST_B2 = 16'h0000;
  localparam logic [15:0] RST_A1 = 16'h0000;
  localparam logic [15:0] RST_A2 = 16'h0000;

  typedef logic [COEF_NUM-1:0][15:0] coef_bank_t;

  localparam coef_bank_t COEF_RESET = {RST_A2, RST_A1, RST_B2, RST_B1, RST_B0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

  // True when the address selects one of the five coefficients.
  function automatic logic addr_legal(input logic [2:0] addr);
    return (addr <= COEF_A2);
  endfunction

endpackage

// File: rtl/i16_coef_bank.sv
// Five-entry 16-bit coefficient register bank with a single-entry write
// port and a whole-bank parallel load. Parallel load has priority.
module i16_coef_bank
  import i16_coef_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic        load,
  input  coef_bank_t  load_data,
  output coef_bank_t  regs
);

  coef_bank_t regs_q;
  coef_bank_t regs_d;

  // Next bank contents: full load, single legal write, or hold.
  always_comb begin
    regs_d = regs_q;
    if (load) begin
      regs_d = load_data;
    end else if (we && addr_legal(waddr)) begin
      for (int i = 0; i < COEF_NUM; i++) begin
        if (waddr == 3'(i)) begin
          regs_d[i] = wdata;
        end else begin
          regs_d[i] = regs_q[i];
        end
      end
    end else begin
      regs_d = regs_q;
    end
  end

  // Bank storage, reset to the pass-through coefficient set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= COEF_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign regs = regs_q;

endmodule

// File: rtl/i16_coef_loader.sv
// Double-buffered biquad coefficient loader. The host fills a shadow bank;
// a commit arms a swap that copies shadow to active on the next sample
// boundary, so the filter never sees a half-updated coefficient set.
module i16_coef_loader
  import i16_coef_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_addr,
  input  logic [15:0]        wr_data,
  input  logic               commit,
  input  logic               sample_en,
  output logic signed [15:0] b_0,
  output logic signed [15:0] b_1,
  output logic signed [15:0] b_2,
  output logic signed [15:0] a_1,
  output logic signed [15:0] a_2,
  output logic               pending,
  output logic               swap_done,
  output logic               addr_err
);

  state_e     state_q;
  state_e     state_d;
  logic       wr_ready_q;
  logic       wr_ready_d;
  logic       pending_q;
  logic       pending_d;
  logic       swap_done_q;
  logic       swap_done_d;
  logic       addr_err_q;
  logic       addr_err_d;
  logic       wr_fire_s;
  logic       swap_go_s;
  coef_bank_t shadow_regs;
  coef_bank_t active_regs;

  // Handshake and swap qualification; a swap needs ARMED, which is only
  // reached on the edge after COMMIT, so a coincident strobe cannot fire.
  always_comb begin
    wr_fire_s  = wr_valid & wr_ready_q;
    swap_go_s  = (state_q == ST_ARMED) & sample_en;
    addr_err_d = wr_fire_s & ~addr_legal(wr_addr);
  end

  // Next-state logic and the registered status outputs derived from it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (sample_en) begin
          state_d = ST_SWAP;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_SWAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    wr_ready_d  = (state_d == ST_IDLE);
    pending_d   = (state_d == ST_ARMED);
    swap_done_d = swap_go_s;
  end

  // Control FSM state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ready_q  <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ready_q  <= wr_ready_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  i16_coef_bank u_shadow (
    .clk       (clk),
    .rst       (rst),
    .we        (wr_fire_s),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .load      (1'b0),
    .load_data ({COEF_NUM{16'h0000}}),
    .regs      (shadow_regs)
  );

  i16_coef_bank u_active (
    .clk       (clk),
    .rst       (rst),
    .we        (1'b0),
    .waddr     (3'd0),
    .wdata     (16'h0000),
    .load      (swap_go_s),
    .load_data (shadow_regs),
    .regs      (active_regs)
  );

  assign b_0       = active_regs[COEF_B0];
  assign b_1       = active_regs[COEF_B1];
  assign b_2       = active_regs[COEF_B2];
  assign a_1       = active_regs[COEF_A1];
  assign a_2       = active_regs[COEF_A2];
  assign wr_ready  = wr_ready_q;
  assign pending   = pending_q;
  assign swap_done = swap_done_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_i16_coef_loader.sv
// Self-checking bench for i16_coef_loader: a table of per-cycle stimulus
// with hand-derived expected outputs fed through a scoreboard queue, plus
// hand-written reset and abort sequences.
module tb_i16_coef_loader;

  typedef struct {
    logic        rdy;
    logic        pend;
    logic        sd;
    logic        ae;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [15:0] b2;
    logic [15:0] a1;
    logic [15:0] a2;
  } exp_t;

  typedef struct {
    logic        wv;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        cm;
    logic        se;
    exp_t        exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        commit;
  logic        sample_en;
  logic [15:0] b_0;
  logic [15:0] b_1;
  logic [15:0] b_2;
  logic [15:0] a_1;
  logic [15:0] a_2;
  logic        pending;
  logic        swap_done;
  logic        addr_err;

  int   checks;
  int   errors;
  vec_t vecs[$];
  exp_t exp_q[$];

  i16_coef_loader dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .commit    (commit),
    .sample_en (sample_en),
    .b_0       (b_0),
    .b_1       (b_1),
    .b_2       (b_2),
    .a_1       (a_1),
    .a_2       (a_2),
    .pending   (pending),
    .swap_done (swap_done),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wv, input logic [2:0] addr, input logic [15:0] data,
                     input logic cm, input logic se,
                     input logic rdy, input logic pend, input logic sd, input logic ae,
                     input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                     input logic [15:0] a1, input logic [15:0] a2);
    vec_t v;
    v.wv = wv; v.addr = addr; v.data = data; v.cm = cm; v.se = se;
    v.exp.rdy = rdy; v.exp.pend = pend; v.exp.sd = sd; v.exp.ae = ae;
    v.exp.b0 = b0; v.exp.b1 = b1; v.exp.b2 = b2; v.exp.a1 = a1; v.exp.a2 = a2;
    vecs.push_back(v);
  endtask

  task automatic check_coefs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
    check({tag, " b_0"}, b_0, e0);
    check({tag, " b_1"}, b_1, e1);
    check({tag, " b_2"}, b_2, e2);
    check({tag, " a_1"}, a_1, e3);
    check({tag, " a_2"}, a_2, e4);
  endtask

  task automatic drive(input logic wv, input logic [2:0] addr, input logic [15:0] data,
                       input logic cm, input logic se);
    wr_valid = wv; wr_addr = addr; wr_data = data; commit = cm; sample_en = se;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

    // Expected outputs after each edge (wv addr data cm se | rdy pend sd ae | b0 b1 b2 a1 a2).
    // Atomic update of b_0 and a_1.
    add(1'b1, 3'd0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1'b1, 3'd3, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    // Backpressure: write to b_2 held while armed and during swap.
    add(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    add(1'b1, 3'd2, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    add(1'b1, 3'd2, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    add(1'b1, 3'd2, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    add(1'b1, 3'd2, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    // Illegal address: one ADDR_ERR pulse, swap leaves outputs unchanged.
    add(1'b1, 3'd6, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    // Write + commit + strobe together: no swap on that strobe; second commit ignored.
    add(1'b1, 3'd4, 16'h0123, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0000);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    // Commit with no writes re-applies; commit during SWAP and strobe in IDLE do nothing.
    add(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    add(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    // Partial update of b_1 only; the rest of the shadow bank is retained.
    add(1'b1, 3'd1, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    add(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h7FFF, 16'hC000, 16'h0123);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'hABCD, 16'h7FFF, 16'hC000, 16'h0123);
    add(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'hABCD, 16'h7FFF, 16'hC000, 16'h0123);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_coefs("reset", 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check("reset pending", {15'd0, pending}, 16'h0000);
    check("reset swap_done", {15'd0, swap_done}, 16'h0000);
    check("reset addr_err", {15'd0, addr_err}, 16'h0000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset wr_ready", {15'd0, wr_ready}, 16'h0001);

    // Table-driven run through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      drive(vecs[i].wv, vecs[i].addr, vecs[i].data, vecs[i].cm, vecs[i].se);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d wr_ready", i), {15'd0, wr_ready}, {15'd0, e.rdy});
      check($sformatf("v%0d pending", i), {15'd0, pending}, {15'd0, e.pend});
      check($sformatf("v%0d swap_done", i), {15'd0, swap_done}, {15'd0, e.sd});
      check($sformatf("v%0d addr_err", i), {15'd0, addr_err}, {15'd0, e.ae});
      check_coefs($sformatf("v%0d", i), e.b0, e.b1, e.b2, e.a1, e.a2);
    end
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

    // Mid-run asynchronous reset while armed aborts the commit.
    drive(1'b1, 3'd0, 16'h2222, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    check("abort armed pending", {15'd0, pending}, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check_coefs("async reset", 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check("async reset pending", {15'd0, pending}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample_en = c[0];
      @(posedge clk);
      #1;
      check($sformatf("abort c%0d swap_done", c), {15'd0, swap_done}, 16'h0000);
      check($sformatf("abort c%0d b_0", c), b_0, 16'h4000);
      check($sformatf("abort c%0d pending", c), {15'd0, pending}, 16'h0000);
    end
    sample_en = 1'b0;
    check("abort wr_ready", {15'd0, wr_ready}, 16'h0001);

    // Shadow bank was reset too: a fresh swap re-applies pass-through values.
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    check("shadow reset swap_done", {15'd0, swap_done}, 16'h0001);
    check_coefs("shadow reset", 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check("final swap_done", {15'd0, swap_done}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i16_coef_loader.md
I16_COEF_LOADER -- requirements
Module: i16_coef_loader

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 WR_VALID  input  1  write request from the host side.
REQ-005 WR_READY  output  1  loader accepts the write; a transfer occurs when WR_VALID and WR_READY are both high on a rising edge.
REQ-006 WR_ADDR  input  3  coefficient select: 0=b_0, 1=b_1, 2=b_2, 3=a_1, 4=a_2; 5..7 are illegal.
REQ-007 WR_DATA  input  16  signed coefficient value.
REQ-008 COMMIT  input  1  single-cycle request to apply the shadow bank.
REQ-009 SAMPLE_EN  input  1  sample-boundary strobe, shared with the filter's input-sample cadence.
REQ-010 b_0, b_1, b_2, a_1, a_2  output  16 signed each  active coefficients, wired directly to the biquad coefficient terminals.
REQ-011 PENDING  output  1  high while a commit is waiting for a sample boundary.
REQ-012 SWAP_DONE  output  1  one-cycle pulse on the cycle the active bank updates.
REQ-013 ADDR_ERR  output  1  one-cycle pulse when an accepted write has an illegal address.

Function
REQ-014 SHALL hold two banks of five 16-bit registers: shadow (written by the host) and active (drives the outputs).
REQ-015 FSM states: IDLE, ARMED, SWAP.
- IDLE: WR_READY=1. COMMIT moves the FSM to ARMED.
- ARMED: WR_READY=0, PENDING=1. The first SAMPLE_EN on a cycle strictly after the COMMIT cycle moves the FSM to SWAP.
- SWAP: active <= shadow for all five registers at once, SWAP_DONE=1, WR_READY=0; next state is IDLE.
REQ-016 Legal accepted write: shadow[WR_ADDR] <= WR_DATA on that edge; the active bank is unaffected.
REQ-017 Illegal accepted write: no register changes; ADDR_ERR pulses high for exactly the following cycle.
REQ-018 Write and COMMIT in the same IDLE cycle: the write lands in shadow and is included in the pending swap.
REQ-019 COMMIT while ARMED or SWAP SHALL be ignored; it is not queued.
REQ-020 SAMPLE_EN coincident with COMMIT SHALL NOT trigger the swap; the next SAMPLE_EN does.
REQ-021 SAMPLE_EN in IDLE SHALL have no effect.
REQ-022 The shadow bank retains its contents after a swap, so partial updates of single coefficients are allowed.
REQ-023 COMMIT with no intervening writes SHALL still complete a swap, re-applying the shadow bank.
REQ-024 Active outputs SHALL change only in SWAP, never mid-sample; all five change on the same edge.
REQ-025 Latency: the active outputs update on the rising edge after the qualifying SAMPLE_EN.

Reset
REQ-026 On RST, both banks SHALL take the pass-through values b_0=16'h4000 and b_1=b_2=a_1=a_2=0.
REQ-027 On RST, the FSM SHALL go to IDLE; PENDING, SWAP_DONE and ADDR_ERR go to 0; WR_READY goes to 1 after reset deasserts.
REQ-028 RST while ARMED SHALL abort the commit; no swap occurs afterwards.

Structure
REQ-029 A shared package SHALL hold:
- the address constants (COEF_B0..COEF_A2, COEF_NUM=5);
- the reset coefficient constants;
- the FSM state encoding.
REQ-030 SHALL contain one sub-module, i16_coef_bank: a five-entry 16-bit register bank with write-enable, address, and parallel-load ports, instantiated twice (shadow and active).

Verification
REQ-031 Reset check: assert RST mid-run -> outputs read 0x4000, 0, 0, 0, 0 immediately (asynchronous); PENDING=0.
REQ-032 Atomic update:
- Stimulus: write b_0=0x1000, a_1=0xC000, then COMMIT; SAMPLE_EN three cycles later.
- Response: outputs unchanged until the edge after SAMPLE_EN; then both change together and SWAP_DONE=1 for one cycle.
REQ-033 Backpressure:
- Stimulus: COMMIT, then hold WR_VALID=1 with addr 2, data 0x7FFF, while ARMED.
- Response: WR_READY=0 throughout; the write is accepted only after return to IDLE; b_2 stays unchanged until the next swap.
REQ-034 Illegal address: write addr 6, data 0x1234 -> ADDR_ERR pulses once; a subsequent commit and swap leaves all outputs unchanged.
REQ-035 Coincident COMMIT and SAMPLE_EN -> no swap on that strobe; the swap occurs on the next SAMPLE_EN; a second COMMIT while ARMED produces only one SWAP_DONE.
REQ-036 Abort: COMMIT then RST before SAMPLE_EN -> no SWAP_DONE ever occurs; outputs hold the reset values.
